// File: rtl/wb_commit_unit_if.sv
// rtl/wb_commit_unit_if.sv - execute-to-writeback handshake and result bundle
//
// Purpose: carries one executed instruction (RIP, up to two destination
// results and two source-release indices) from execute into the commit unit.
// Ports (modports):
//   master - execute side: drives everything except wb_ready_out
//   slave  - commit unit : samples the bundle, drives wb_ready_out
interface wb_commit_unit_if #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 64,
    parameter int RIP_W  = 32
);
    logic              wb_valid_in;
    logic              wb_ready_out;
    logic [RIP_W-1:0]  wb_rip_in;
    logic              dst_valid_in;
    logic [IDX_W-1:0]  dst_reg_in;
    logic [DATA_W-1:0] dst_data_in;
    logic              dsts_valid_in;
    logic [IDX_W-1:0]  dsts_reg_in;
    logic [DATA_W-1:0] dsts_data_in;
    logic              src1_valid_in;
    logic [IDX_W-1:0]  src1_reg_in;
    logic              src2_valid_in;
    logic [IDX_W-1:0]  src2_reg_in;

    modport master (
        output wb_valid_in, wb_rip_in,
        output dst_valid_in, dst_reg_in, dst_data_in,
        output dsts_valid_in, dsts_reg_in, dsts_data_in,
        output src1_valid_in, src1_reg_in, src2_valid_in, src2_reg_in,
        input  wb_ready_out
    );

    modport slave (
        input  wb_valid_in, wb_rip_in,
        input  dst_valid_in, dst_reg_in, dst_data_in,
        input  dsts_valid_in, dsts_reg_in, dsts_data_in,
        input  src1_valid_in, src1_reg_in, src2_valid_in, src2_reg_in,
        output wb_ready_out
    );
endinterface

// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - registered writeback/commit stage with register file and scoreboard
//
// Purpose: on each accepted instruction writes up to two results into the
// architectural register file, releases scoreboard bits and hands the RIP to
// the retire interface through a single-entry output register.
// Ports:
//   clk, reset_n             - clock, synchronous active-low reset
//   wb                       - execute bundle (wb_commit_unit_if.slave)
//   rsv_valid_in/rsv_reg_in  - decode reserve request
//   rd_addr_a/b, rd_data_a/b - combinational operand read ports
//   in_use_out               - registered scoreboard bitmap
//   ret_valid_out/ret_ready_in/ret_rip_out - retire handshake
//   retire_count_out         - retired-instruction counter (wraps)
module wb_commit_unit #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int DATA_W   = 64,
    parameter int RIP_W    = 32,
    parameter int CNT_W    = 32,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    wb_commit_unit_if.slave     wb,
    input  logic                rsv_valid_in,
    input  logic [IDX_W-1:0]    rsv_reg_in,
    input  logic [IDX_W-1:0]    rd_addr_a,
    input  logic [IDX_W-1:0]    rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic [NUM_REGS-1:0] in_use_out,
    output logic                ret_valid_out,
    input  logic                ret_ready_in,
    output logic [RIP_W-1:0]    ret_rip_out,
    output logic [CNT_W-1:0]    retire_count_out
);
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] in_use_q, in_use_d;
    logic                ret_valid_q, ret_valid_d;
    logic [RIP_W-1:0]    ret_rip_q, ret_rip_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] clr_mask, set_mask;
    logic                accept;
    logic                retire;

    // The retire slot can take a new entry when empty or draining this cycle.
    assign wb.wb_ready_out = !ret_valid_q || ret_ready_in;
    assign accept          = wb.wb_valid_in && wb.wb_ready_out;
    assign retire          = ret_valid_q && ret_ready_in;

    always_comb begin
        regs_d      = regs_q;
        clr_mask    = '0;
        set_mask    = '0;
        ret_valid_d = ret_valid_q;
        ret_rip_d   = ret_rip_q;
        cnt_d       = cnt_q;

        if (retire) begin
            cnt_d       = cnt_q + CNT_W'(1);
            ret_valid_d = 1'b0;
        end

        if (accept) begin
            // Special written first so the primary overwrites on an index clash.
            if (wb.dsts_valid_in) regs_d[wb.dsts_reg_in] = wb.dsts_data_in;
            if (wb.dst_valid_in)  regs_d[wb.dst_reg_in]  = wb.dst_data_in;
            if (wb.src1_valid_in) clr_mask[wb.src1_reg_in] = 1'b1;
            if (wb.src2_valid_in) clr_mask[wb.src2_reg_in] = 1'b1;
            if (wb.dst_valid_in)  clr_mask[wb.dst_reg_in]  = 1'b1;
            if (wb.dsts_valid_in) clr_mask[wb.dsts_reg_in] = 1'b1;
            ret_valid_d = 1'b1;
            ret_rip_d   = wb.wb_rip_in;
        end

        // Reserve is independent of accept and applied after release.
        if (rsv_valid_in) set_mask[rsv_reg_in] = 1'b1;
        in_use_d = (in_use_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        if (BYPASS != 0 && accept) begin
            if (wb.dsts_valid_in && wb.dsts_reg_in == rd_addr_a) rd_data_a = wb.dsts_data_in;
            if (wb.dst_valid_in  && wb.dst_reg_in  == rd_addr_a) rd_data_a = wb.dst_data_in;
            if (wb.dsts_valid_in && wb.dsts_reg_in == rd_addr_b) rd_data_b = wb.dsts_data_in;
            if (wb.dst_valid_in  && wb.dst_reg_in  == rd_addr_b) rd_data_b = wb.dst_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            in_use_q    <= '0;
            ret_valid_q <= 1'b0;
            ret_rip_q   <= '0;
            cnt_q       <= '0;
        end else begin
            regs_q      <= regs_d;
            in_use_q    <= in_use_d;
            ret_valid_q <= ret_valid_d;
            ret_rip_q   <= ret_rip_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_use_out       = in_use_q;
    assign ret_valid_out    = ret_valid_q;
    assign ret_rip_out      = ret_rip_q;
    assign retire_count_out = cnt_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb/tb_wb_commit_unit.sv - self-checking bench for wb_commit_unit (bypass/32-bit and no-bypass/4-bit copies)
module tb_wb_commit_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid, dst_v, dsts_v, s1_v, s2_v, rsv_v, ret_ready;
    logic [31:0] wb_rip;
    logic [3:0]  dst_r, dsts_r, s1_r, s2_r, rsv_r, rd_a, rd_b;
    logic [63:0] dst_d, dsts_d;

    logic [63:0] a_rd_a, a_rd_b, b_rd_a, b_rd_b;
    logic [15:0] a_use, b_use;
    logic        a_rv, b_rv;
    logic [31:0] a_rip, b_rip, a_cnt;
    logic [3:0]  b_cnt;

    // Reference model state
    logic [63:0] m_regs [16];
    logic [15:0] m_use;
    logic        m_rv;
    logic [31:0] m_rip;
    logic [31:0] m_cnt;
    logic [31:0] retired [$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_commit_unit_if #(.IDX_W(4), .DATA_W(64), .RIP_W(32)) ifa ();
    wb_commit_unit_if #(.IDX_W(4), .DATA_W(64), .RIP_W(32)) ifb ();

    assign ifa.wb_valid_in = wb_valid;   assign ifb.wb_valid_in = wb_valid;
    assign ifa.wb_rip_in = wb_rip;       assign ifb.wb_rip_in = wb_rip;
    assign ifa.dst_valid_in = dst_v;     assign ifb.dst_valid_in = dst_v;
    assign ifa.dst_reg_in = dst_r;       assign ifb.dst_reg_in = dst_r;
    assign ifa.dst_data_in = dst_d;      assign ifb.dst_data_in = dst_d;
    assign ifa.dsts_valid_in = dsts_v;   assign ifb.dsts_valid_in = dsts_v;
    assign ifa.dsts_reg_in = dsts_r;     assign ifb.dsts_reg_in = dsts_r;
    assign ifa.dsts_data_in = dsts_d;    assign ifb.dsts_data_in = dsts_d;
    assign ifa.src1_valid_in = s1_v;     assign ifb.src1_valid_in = s1_v;
    assign ifa.src1_reg_in = s1_r;       assign ifb.src1_reg_in = s1_r;
    assign ifa.src2_valid_in = s2_v;     assign ifb.src2_valid_in = s2_v;
    assign ifa.src2_reg_in = s2_r;       assign ifb.src2_reg_in = s2_r;

    wb_commit_unit #(.CNT_W(32), .BYPASS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .wb(ifa),
        .rsv_valid_in(rsv_v), .rsv_reg_in(rsv_r),
        .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_data_a(a_rd_a), .rd_data_b(a_rd_b),
        .in_use_out(a_use), .ret_valid_out(a_rv), .ret_ready_in(ret_ready),
        .ret_rip_out(a_rip), .retire_count_out(a_cnt)
    );

    wb_commit_unit #(.CNT_W(4), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .wb(ifb),
        .rsv_valid_in(rsv_v), .rsv_reg_in(rsv_r),
        .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_data_a(b_rd_a), .rd_data_b(b_rd_b),
        .in_use_out(b_use), .ret_valid_out(b_rv), .ret_ready_in(ret_ready),
        .ret_rip_out(b_rip), .retire_count_out(b_cnt)
    );

    function automatic bit m_accept();
        return wb_valid && (!m_rv || ret_ready);
    endfunction

    // Operand value as seen by decode: forwarded result when bypassing, else array.
    function automatic logic [63:0] exp_rd(input logic [3:0] addr, input bit byp);
        logic [63:0] v;
        v = m_regs[addr];
        if (byp && m_accept()) begin
            if (dst_v && dst_r == addr) v = dst_d;
            else if (dsts_v && dsts_r == addr) v = dsts_d;
        end
        return v;
    endfunction

    task automatic idle();
        wb_valid = 0; dst_v = 0; dsts_v = 0; s1_v = 0; s2_v = 0; rsv_v = 0;
    endtask

    // Advance one clock and apply the specification's commit rules to the model.
    task automatic tick();
        bit acc;
        if (a_rv && ret_ready) retired.push_back(a_rip);
        @(posedge clk);
        acc = m_accept();
        if (!reset_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_use = '0; m_rv = 0; m_rip = '0; m_cnt = '0;
        end else begin
            if (m_rv && ret_ready) m_cnt = m_cnt + 1;
            if (acc) begin
                if (dst_v) m_regs[dst_r] = dst_d;
                else if (dsts_v) m_regs[dsts_r] = dsts_d;
                if (dst_v && dsts_v && dst_r != dsts_r) m_regs[dsts_r] = dsts_d;
                if (s1_v) m_use[s1_r] = 0;
                if (s2_v) m_use[s2_r] = 0;
                if (dst_v) m_use[dst_r] = 0;
                if (dsts_v) m_use[dsts_r] = 0;
                m_rip = wb_rip;
            end
            if (rsv_v) m_use[rsv_r] = 1;
            m_rv = acc ? 1'b1 : (m_rv && !ret_ready);
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); ret_ready = 0; reset_n = 0; rd_a = 0; rd_b = 0; wb_rip = 0;
        dst_r = 0; dsts_r = 0; s1_r = 0; s2_r = 0; rsv_r = 0; dst_d = 0; dsts_d = 0;
        tick(); tick();
        reset_n = 1;
        tick();
        for (int i = 0; i < 16; i++) begin
            rd_a = 4'(i); rd_b = 4'(15 - i); #1;
            tests++; if (a_rd_a !== 64'd0 || b_rd_a !== 64'd0) begin fails++;
                $display("FAIL reset_rd_a[%0d] got %h/%h want 0", i, a_rd_a, b_rd_a); end
            tests++; if (a_rd_b !== 64'd0 || b_rd_b !== 64'd0) begin fails++;
                $display("FAIL reset_rd_b[%0d] got %h/%h want 0", 15 - i, a_rd_b, b_rd_b); end
        end
        tests++; if (a_use !== 16'h0 || b_use !== 16'h0) begin fails++;
            $display("FAIL reset_in_use got %h/%h want 0000", a_use, b_use); end
        tests++; if (a_cnt !== 32'd0 || b_cnt !== 4'd0 || a_rv !== 1'b0) begin fails++;
            $display("FAIL reset_cnt got %0d/%0d rv %b want 0/0 rv 0", a_cnt, b_cnt, a_rv); end
    endtask

    task automatic test_dual_write();
        idle(); ret_ready = 1; rsv_v = 1; rsv_r = 3;
        tick();
        tests++; if (a_use[3] !== 1'b1) begin fails++;
            $display("FAIL dual_rsv in_use[3] got %b want 1", a_use[3]); end
        idle(); wb_valid = 1; wb_rip = 32'hCAFE_0010;
        dst_v = 1; dst_r = 3; dst_d = 64'hAAAA; dsts_v = 1; dsts_r = 3; dsts_d = 64'h5555;
        tick();
        idle(); rd_a = 3; #1;
        tests++; if (a_rd_a !== 64'hAAAA || b_rd_a !== 64'hAAAA) begin fails++;
            $display("FAIL dual_prio got %h/%h want aaaa", a_rd_a, b_rd_a); end
        tests++; if (a_use[3] !== 1'b0 || a_rv !== 1'b1 || a_rip !== 32'hCAFE_0010) begin fails++;
            $display("FAIL dual_ret use %b rv %b rip %h want 0 1 cafe0010", a_use[3], a_rv, a_rip); end
        tick();
        tests++; if (a_cnt !== 32'd1 || b_cnt !== 4'd1 || a_rv !== 1'b0) begin fails++;
            $display("FAIL dual_cnt got %0d/%0d rv %b want 1/1 rv 0", a_cnt, b_cnt, a_rv); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] base;
        logic [31:0] want [3];
        want[0] = 32'h100; want[1] = 32'h104; want[2] = 32'h108;
        idle(); ret_ready = 1; tick();
        base = m_cnt; retired.delete();
        ret_ready = 0; wb_valid = 1; wb_rip = 32'h100; #1;
        tests++; if (ifa.wb_ready_out !== 1'b1) begin fails++;
            $display("FAIL bp_ready0 got %b want 1", ifa.wb_ready_out); end
        tick();
        wb_rip = 32'h104;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++; if (ifa.wb_ready_out !== 1'b0 || ifb.wb_ready_out !== 1'b0) begin fails++;
                $display("FAIL bp_stall%0d got %b/%b want 0", k, ifa.wb_ready_out, ifb.wb_ready_out); end
            tick();
        end
        tests++; if (a_rip !== 32'h100 || a_rv !== 1'b1) begin fails++;
            $display("FAIL bp_hold rip %h rv %b want 100 1", a_rip, a_rv); end
        ret_ready = 1; tick();
        tests++; if (a_rip !== 32'h104 || a_rv !== 1'b1) begin fails++;
            $display("FAIL bp_replace rip %h rv %b want 104 1", a_rip, a_rv); end
        wb_rip = 32'h108; tick();
        idle(); tick();
        tests++; if (a_cnt !== base + 3) begin fails++;
            $display("FAIL bp_count got %0d want %0d", a_cnt, base + 3); end
        tests++; if (retired.size() != 3) begin fails++;
            $display("FAIL bp_retired_n got %0d want 3", retired.size()); end
        for (int k = 0; k < 3 && k < retired.size(); k++) begin
            tests++; if (retired[k] !== want[k]) begin fails++;
                $display("FAIL bp_order[%0d] got %h want %h", k, retired[k], want[k]); end
        end
    endtask

    task automatic test_collision();
        idle(); ret_ready = 1;
        wb_valid = 1; wb_rip = 32'h200; s1_v = 1; s1_r = 5; rsv_v = 1; rsv_r = 5;
        tick();
        tests++; if (a_use[5] !== 1'b1 || b_use[5] !== 1'b1) begin fails++;
            $display("FAIL coll_set got %b/%b want 1", a_use[5], b_use[5]); end
        rsv_v = 0; wb_rip = 32'h204;
        tick();
        tests++; if (a_use[5] !== 1'b0 || b_use[5] !== 1'b0) begin fails++;
            $display("FAIL coll_clr got %b/%b want 0", a_use[5], b_use[5]); end
        idle(); tick();
    endtask

    task automatic test_bypass();
        logic [63:0] old;
        idle(); ret_ready = 1;
        old = m_regs[7];
        wb_valid = 1; wb_rip = 32'h300; dst_v = 1; dst_r = 7; dst_d = 64'h1234; rd_a = 7; rd_b = 7; #1;
        tests++; if (a_rd_a !== 64'h1234) begin fails++;
            $display("FAIL byp_on got %h want 1234", a_rd_a); end
        tests++; if (b_rd_a !== old) begin fails++;
            $display("FAIL byp_off got %h want %h", b_rd_a, old); end
        tick();
        idle(); #1;
        tests++; if (b_rd_a !== 64'h1234 || a_rd_b !== 64'h1234) begin fails++;
            $display("FAIL byp_next got %h/%h want 1234", b_rd_a, a_rd_b); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wb_valid = ($urandom_range(0, 3) != 0); wb_rip = $urandom;
            dst_v = $urandom_range(0, 1); dst_r = 4'($urandom); dst_d = {$urandom, $urandom};
            dsts_v = $urandom_range(0, 1); dsts_r = ($urandom_range(0, 3) == 0) ? dst_r : 4'($urandom);
            dsts_d = {$urandom, $urandom};
            s1_v = $urandom_range(0, 1); s1_r = 4'($urandom);
            s2_v = $urandom_range(0, 1); s2_r = 4'($urandom);
            rsv_v = $urandom_range(0, 1); rsv_r = 4'($urandom);
            rd_a = ($urandom_range(0, 1) != 0) ? dst_r : 4'($urandom);
            rd_b = ($urandom_range(0, 1) != 0) ? dsts_r : 4'($urandom);
            ret_ready = ($urandom_range(0, 2) != 0);
            #1;
            tests++; if (ifa.wb_ready_out !== (!m_rv || ret_ready) || ifb.wb_ready_out !== (!m_rv || ret_ready)) begin
                fails++; $display("FAIL rnd_ready[%0d] got %b/%b want %b", n, ifa.wb_ready_out, ifb.wb_ready_out, !m_rv || ret_ready); end
            tests++; if (a_rd_a !== exp_rd(rd_a, 1) || a_rd_b !== exp_rd(rd_b, 1)) begin fails++;
                $display("FAIL rnd_rd_byp[%0d] got %h %h want %h %h", n, a_rd_a, a_rd_b, exp_rd(rd_a, 1), exp_rd(rd_b, 1)); end
            tests++; if (b_rd_a !== exp_rd(rd_a, 0) || b_rd_b !== exp_rd(rd_b, 0)) begin fails++;
                $display("FAIL rnd_rd_arr[%0d] got %h %h want %h %h", n, b_rd_a, b_rd_b, exp_rd(rd_a, 0), exp_rd(rd_b, 0)); end
            tick();
            tests++; if (a_use !== m_use || b_use !== m_use) begin fails++;
                $display("FAIL rnd_use[%0d] got %h/%h want %h", n, a_use, b_use, m_use); end
            tests++; if (a_rv !== m_rv || b_rv !== m_rv || (m_rv && (a_rip !== m_rip || b_rip !== m_rip))) begin fails++;
                $display("FAIL rnd_ret[%0d] got %b %h want %b %h", n, a_rv, a_rip, m_rv, m_rip); end
            tests++; if (a_cnt !== m_cnt || b_cnt !== m_cnt[3:0]) begin fails++;
                $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d", n, a_cnt, b_cnt, m_cnt); end
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        idle(); ret_ready = 0; wb_valid = 1; wb_rip = 32'h400;
        dst_v = 1; dst_r = 9; dst_d = 64'hDEAD; rsv_v = 1; rsv_r = 2;
        tick();
        tests++; if (a_rv !== 1'b1) begin fails++;
            $display("FAIL mid_pre rv got %b want 1", a_rv); end
        dst_r = 10; reset_n = 0;
        tick();
        reset_n = 1; idle(); rd_a = 9; rd_b = 10; #1;
        tests++; if (a_rv !== 1'b0 || b_rv !== 1'b0 || a_rip !== 32'd0) begin fails++;
            $display("FAIL mid_ret rv %b/%b rip %h want 0", a_rv, b_rv, a_rip); end
        tests++; if (a_use !== 16'h0 || a_cnt !== 32'd0 || b_cnt !== 4'd0) begin fails++;
            $display("FAIL mid_state use %h cnt %0d/%0d want 0", a_use, a_cnt, b_cnt); end
        tests++; if (a_rd_a !== 64'd0 || a_rd_b !== 64'd0) begin fails++;
            $display("FAIL mid_regs got %h %h want 0", a_rd_a, a_rd_b); end
    endtask

    task automatic test_wrap();
        idle(); ret_ready = 1;
        for (int k = 0; k < 17; k++) begin
            wb_valid = 1; wb_rip = 32'h500 + 32'(k * 4); tick();
        end
        idle(); tick();
        tests++; if (b_cnt !== 4'd1) begin fails++;
            $display("FAIL wrap_cnt4 got %0d want 1", b_cnt); end
        tests++; if (a_cnt !== 32'd17) begin fails++;
            $display("FAIL wrap_cnt32 got %0d want 17", a_cnt); end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_back_pressure();
        test_collision();
        test_bypass();
        test_random();
        test_reset_midflight();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
